pool_wb_desc_gen: RTL and testbench
===================================

# pool_wb_desc_gen

Write-back descriptor sequencer for the pooling unit. On an instruction start it walks the pooled output tile and pushes one descriptor per gathered output vector into the write-back descriptor FIFO: RTM address, mask bit and last flag. The RTM writer pops these descriptors as gathered data arrives. The block then waits for the writer's completion pulse and reports instruction done to the pool controller.

## Interface
- ADDR_W, 14, RTM address width (equals clog2(RTM_DEPTH))
- CNT_W, 16, width of the vector and group counters
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle instruction start pulse
- base_addr  in  ADDR_W  RTM address of the first output vector
- grp_stride  in  ADDR_W  address increment between channel groups
- n_grp  in  CNT_W  number of channel groups
- n_slot  in  CNT_W  gathered vectors per group (descriptors per group)
- n_vec  in  CNT_W  valid vectors per group; slots at index >= n_vec are masked
- desc_fifo_prog_full  in  1  FIFO programmable-full (asserts with ≥2 free entries left)
- desc_fifo_wr_en  out  1  descriptor push
- desc_fifo_din_addr  out  ADDR_W  descriptor RTM address
- desc_fifo_din_mask  out  1  1 = suppress RTM write for this vector
- desc_fifo_din_last  out  1  final descriptor of the instruction
- wb_done_pulse  in  1  completion pulse from the RTM writer
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle instruction-complete pulse
- stall_cycles  out  32  FIFO-full stall counter (see Configuration)

## Operation
- States: IDLE, RUN, WAIT_WB.
- IDLE: start latches all parameters and clears counters v=0 and g=0. The block enters RUN, or stays in IDLE and pulses done if n_grp==0 or n_slot==0. start outside IDLE is ignored.
- RUN: on each cycle with desc_fifo_prog_full low, push one descriptor.
  - addr = base + g*grp_stride + v, computed modulo 2^ADDR_W so it wraps silently.
  - mask = (v >= n_vec); n_vec > n_slot therefore leaves every slot unmasked.
  - last = (g==n_grp-1 && v==n_slot-1).
- Counter order: v increments first, wraps to 0 at n_slot-1, then g increments.
- The group address offset is kept as a running accumulator: it adds grp_stride on each group wrap. No multiplier is used.
- After the last push the block enters WAIT_WB.
- WAIT_WB: wb_done_pulse leads to done for one cycle, busy low, and a return to IDLE. wb_done_pulse in IDLE or RUN is ignored.
- Reset: all outputs and counters go to 0 and state goes to IDLE. Reset mid-instruction abandons it; no done is issued.

## Timing
- All outputs are registered. Reset values: desc_fifo_wr_en=0, desc_fifo_din_*=0, busy=0, done=0, stall_cycles=0.
- start at cycle T:
  - busy=1 from T+1.
  - First descriptor push is visible at T+1 if prog_full is low at T.
- Throughput: 1 descriptor/cycle while prog_full is low. Total pushes = n_grp*n_slot.
- Backpressure: a push issued in cycle C is decided on prog_full sampled in C-1. The threshold of 2 free entries absorbs the in-flight push.
- desc_fifo_din_* hold their last value when wr_en=0.
- Done timing: wb_done_pulse at cycle W in WAIT_WB gives done=1 at W+1 and busy=0 at W+1.
- Zero-work start at T gives done=1 at T+1; busy stays 0.
- A new start is accepted in the same cycle that done is high, since the state is IDLE.

## Configuration
- POOL_WB_DESC_STALL_CNT_EN defined:
  - stall_cycles increments by 1 on every RUN cycle with desc_fifo_prog_full high.
  - It saturates at 2^32-1, is cleared on start, and holds its value after done.
- Undefined: stall_cycles is tied to 0 and the counter logic is not built.

## Test plan
- base=0x10, stride=0x20, n_grp=2, n_slot=4, n_vec=3, FIFO never full:
  - 8 consecutive pushes, addrs 0x10,0x11,0x12,0x13,0x30,0x31,0x32,0x33.
  - mask pattern 0,0,0,1 per group; last only on addr 0x33.
  - A wb_done_pulse 5 cycles later gives done 1 cycle after it.
- prog_full held high for cycles 3-9 of the same run:
  - No pushes are issued while it is high; order and content are unchanged; exactly 8 pushes total.
  - With the macro, stall_cycles=7.
- base=0x3FFE, ADDR_W=14, n_grp=1, n_slot=4, n_vec=4: addrs 0x3FFE,0x3FFF,0x0000,0x0001, no masks.
- n_grp=0, then n_slot=0: start gives done at T+1, no pushes, busy stays 0.
- Further cases:
  - start pulsed again during RUN: ignored, same descriptor stream.
  - wb_done_pulse during RUN: ignored, no early done.
- rstn low mid-RUN after 3 pushes:
  - All outputs go to 0 immediately and no done is issued.
  - The next start replays from v=0, g=0.

Source files
------------

// File: rtl/pool_wb_desc_gen.sv
// Write-back descriptor sequencer: walks the pooled output tile and pushes one
// descriptor per gathered vector. Optional stall counter: POOL_WB_DESC_STALL_CNT_EN.
//
// state   | meaning
// IDLE    | waiting for start; zero-work starts complete here
// RUN     | pushing descriptors while prog_full is low
// WAIT_WB | all descriptors pushed, waiting for the RTM writer to finish
module pool_wb_desc_gen #(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] grp_stride,
  input  logic [CNT_W-1:0]  n_grp,
  input  logic [CNT_W-1:0]  n_slot,
  input  logic [CNT_W-1:0]  n_vec,
  input  logic              desc_fifo_prog_full,
  output logic              desc_fifo_wr_en,
  output logic [ADDR_W-1:0] desc_fifo_din_addr,
  output logic              desc_fifo_din_mask,
  output logic              desc_fifo_din_last,
  input  logic              wb_done_pulse,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_WB} state_t;
  state_t state;

  logic [ADDR_W-1:0] base_q, stride_q, off_q;
  logic [CNT_W-1:0]  ngrp_q, nslot_q, nvec_q, v_q, g_q;

  logic              idle_s, zero_work, push_ok, v_end, d_mask, d_last;
  logic [ADDR_W-1:0] c_base, c_stride, c_off, d_addr;
  logic [CNT_W-1:0]  c_ngrp, c_nslot, c_nvec, c_v, c_g;

  // In IDLE the first descriptor is built straight from the start inputs so it
  // can be pushed on the cycle after start.
  always_comb begin
    idle_s    = (state == IDLE);
    zero_work = (n_grp == '0) || (n_slot == '0);
    c_base    = idle_s ? base_addr  : base_q;
    c_stride  = idle_s ? grp_stride : stride_q;
    c_ngrp    = idle_s ? n_grp      : ngrp_q;
    c_nslot   = idle_s ? n_slot     : nslot_q;
    c_nvec    = idle_s ? n_vec      : nvec_q;
    c_v       = idle_s ? '0 : v_q;
    c_g       = idle_s ? '0 : g_q;
    c_off     = idle_s ? '0 : off_q;
    d_addr    = c_base + c_off + c_v[ADDR_W-1:0];
    d_mask    = (c_v >= c_nvec);
    v_end     = (c_v == c_nslot - CNT_W'(1));
    d_last    = v_end && (c_g == c_ngrp - CNT_W'(1));
    push_ok   = !desc_fifo_prog_full &&
                ((state == RUN) || (idle_s && start && !zero_work));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= IDLE;
      base_q             <= '0;
      stride_q           <= '0;
      off_q              <= '0;
      ngrp_q             <= '0;
      nslot_q            <= '0;
      nvec_q             <= '0;
      v_q                <= '0;
      g_q                <= '0;
      desc_fifo_wr_en    <= 1'b0;
      desc_fifo_din_addr <= '0;
      desc_fifo_din_mask <= 1'b0;
      desc_fifo_din_last <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      desc_fifo_wr_en <= 1'b0;
      done            <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            stride_q <= grp_stride;
            ngrp_q   <= n_grp;
            nslot_q  <= n_slot;
            nvec_q   <= n_vec;
            v_q      <= '0;
            g_q      <= '0;
            off_q    <= '0;
            if (zero_work) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= (push_ok && d_last) ? WAIT_WB : RUN;
            end
          end
        end
        RUN: begin
          if (push_ok && d_last) state <= WAIT_WB;
        end
        WAIT_WB: begin
          if (wb_done_pulse) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Group offset is a running sum of the stride, so no multiplier is needed.
      if (push_ok) begin
        desc_fifo_wr_en    <= 1'b1;
        desc_fifo_din_addr <= d_addr;
        desc_fifo_din_mask <= d_mask;
        desc_fifo_din_last <= d_last;
        if (v_end) begin
          v_q   <= '0;
          g_q   <= c_g + CNT_W'(1);
          off_q <= c_off + c_stride;
        end else begin
          v_q   <= c_v + CNT_W'(1);
          g_q   <= c_g;
          off_q <= c_off;
        end
      end
    end
  end

`ifdef POOL_WB_DESC_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (idle_s && start) begin
      stall_q <= '0;
    end else if ((state == RUN) && desc_fifo_prog_full && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pool_wb_desc_gen.sv
// Self-checking bench for pool_wb_desc_gen: directed and random instructions
// compared against a queue-based descriptor model.
module tb_pool_wb_desc_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [13:0] base_addr, grp_stride;
  logic [15:0] n_grp, n_slot, n_vec;
  logic        desc_fifo_prog_full;
  logic        desc_fifo_wr_en;
  logic [13:0] desc_fifo_din_addr;
  logic        desc_fifo_din_mask, desc_fifo_din_last;
  logic        wb_done_pulse;
  logic        busy, done;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [13:0] addr;
    logic        mask;
    logic        last;
  } desc_t;

  pool_wb_desc_gen #(.ADDR_W(14), .CNT_W(16)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .start               (start),
    .base_addr           (base_addr),
    .grp_stride          (grp_stride),
    .n_grp               (n_grp),
    .n_slot              (n_slot),
    .n_vec               (n_vec),
    .desc_fifo_prog_full (desc_fifo_prog_full),
    .desc_fifo_wr_en     (desc_fifo_wr_en),
    .desc_fifo_din_addr  (desc_fifo_din_addr),
    .desc_fifo_din_mask  (desc_fifo_din_mask),
    .desc_fifo_din_last  (desc_fifo_din_last),
    .wb_done_pulse       (wb_done_pulse),
    .busy                (busy),
    .done                (done),
    .stall_cycles        (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction: start in cycle 0, prog_full high in cycles pf_lo..pf_hi,
  // wb_done_pulse five cycles after the final push.
  task automatic run(input logic [13:0] b, input logic [13:0] s,
                     input logic [15:0] ng, input logic [15:0] ns, input logic [15:0] nv,
                     input int pf_lo, input int pf_hi,
                     input bit restart, input bit early_wb);
    desc_t q[$];
    desc_t d;
    int    total, pushes, stall_exp, wb_at;
    bit    prev_pf, done_seen;

    for (int g = 0; g < int'(ng); g++) begin
      for (int v = 0; v < int'(ns); v++) begin
        d.addr = 14'((int'(b) + g * int'(s) + v) % 16384);
        d.mask = (v >= int'(nv));
        d.last = (g == int'(ng) - 1) && (v == int'(ns) - 1);
        q.push_back(d);
      end
    end
    total = q.size();

    @(posedge clk); #1;
    start = 1'b1; base_addr = b; grp_stride = s;
    n_grp = ng; n_slot = ns; n_vec = nv;
    desc_fifo_prog_full = (pf_lo <= 0) && (pf_hi >= 0);
    prev_pf   = desc_fifo_prog_full;
    pushes    = 0;
    stall_exp = 0;
    wb_at     = -1;
    done_seen = 1'b0;

    for (int c = 1; c <= 400 && !done_seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      wb_done_pulse = 1'b0;
      chk("wr_en", desc_fifo_wr_en, (total > 0) && (pushes < total) && !prev_pf);
      if (desc_fifo_wr_en === 1'b1 && pushes < total) begin
        chk("addr", desc_fifo_din_addr, q[pushes].addr);
        chk("mask", desc_fifo_din_mask, q[pushes].mask);
        chk("last", desc_fifo_din_last, q[pushes].last);
        pushes++;
        if (pushes == total) wb_at = c + 5;
      end
      if (total == 0) begin
        chk("done_zero", done, 1'b1);
        chk("busy_zero", busy, 1'b0);
        done_seen = 1'b1;
      end else if (wb_at >= 0 && c == wb_at + 1) begin
        chk("done", done, 1'b1);
        chk("busy_end", busy, 1'b0);
        done_seen = 1'b1;
      end else begin
        chk("no_done", done, 1'b0);
        chk("busy", busy, 1'b1);
      end
      if (!done_seen) begin
        desc_fifo_prog_full = (c >= pf_lo) && (c <= pf_hi);
        if (total > 0 && pushes < total && desc_fifo_prog_full) stall_exp++;
        prev_pf = desc_fifo_prog_full;
        if (c == wb_at) wb_done_pulse = 1'b1;
        if (restart && c == 2) begin
          start = 1'b1; base_addr = b + 14'h100; n_grp = ng + 16'd1;
        end
        if (early_wb && c == 3) wb_done_pulse = 1'b1;
      end
    end
    if (!done_seen) chk("timeout", 32'd0, 32'd1);
    chk("push_count", pushes, total);
`ifdef POOL_WB_DESC_STALL_CNT_EN
    chk("stall", stall_cycles, stall_exp);
`else
    chk("stall", stall_cycles, 32'd0);
`endif
    desc_fifo_prog_full = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse_end", done, 1'b0);
  endtask

  initial begin
    bit done_after_rst;

    rstn = 1'b0; start = 1'b0; base_addr = '0; grp_stride = '0;
    n_grp = '0; n_slot = '0; n_vec = '0; desc_fifo_prog_full = 1'b0; wb_done_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", desc_fifo_wr_en, 1'b0);
    chk("rst_addr", desc_fifo_din_addr, 14'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall_cycles, 32'd0);
    rstn = 1'b1;

    run(14'h10, 14'h20, 16'd2, 16'd4, 16'd3, 100, 99, 1'b0, 1'b0);
    run(14'h10, 14'h20, 16'd2, 16'd4, 16'd3, 3, 9, 1'b0, 1'b0);
    run(14'h3FFE, 14'h0, 16'd1, 16'd4, 16'd4, 100, 99, 1'b0, 1'b0);
    run(14'h10, 14'h20, 16'd0, 16'd4, 16'd3, 100, 99, 1'b0, 1'b0);
    run(14'h10, 14'h20, 16'd2, 16'd0, 16'd3, 100, 99, 1'b0, 1'b0);
    run(14'h10, 14'h20, 16'd2, 16'd4, 16'd3, 100, 99, 1'b1, 1'b1);
    run(14'h5, 14'h7, 16'd1, 16'd1, 16'd0, 100, 99, 1'b0, 1'b0);
    run(14'h200, 14'h3FF0, 16'd3, 16'd2, 16'd9, 0, 2, 1'b0, 1'b0);

    // Reset after the third push of a running instruction.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 14'h10; grp_stride = 14'h20;
    n_grp = 16'd2; n_slot = 16'd4; n_vec = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_wr_en", desc_fifo_wr_en, 1'b1);
    chk("pre_rst_addr", desc_fifo_din_addr, 14'h12);
    rstn = 1'b0;
    #1;
    chk("midrst_wr_en", desc_fifo_wr_en, 1'b0);
    chk("midrst_addr", desc_fifo_din_addr, 14'h0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_stall", stall_cycles, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    done_after_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || desc_fifo_wr_en === 1'b1) done_after_rst = 1'b1;
      if (i == 2) wb_done_pulse = 1'b1;
      else wb_done_pulse = 1'b0;
    end
    chk("no_done_after_rst", done_after_rst, 1'b0);
    run(14'h10, 14'h20, 16'd2, 16'd4, 16'd3, 100, 99, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int lo;
      lo = int'($urandom_range(0, 6));
      run(14'($urandom), 14'($urandom), 16'($urandom_range(1, 3)),
          16'($urandom_range(1, 5)), 16'($urandom_range(0, 6)),
          lo, lo + int'($urandom_range(0, 4)), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
